// File: rtl/decode_execute.sv
// Two-stage RV32I integer datapath: decode (regfile, immediates, operand bypass)
// feeding execute (ALU, result register); writeback lands one edge after execute.
module decode_execute #(
   parameter int XLEN = 32,
   parameter int REGS = 32
) (
   input  logic            req,
   input  logic            reset,
   input  logic [31:0]     instr_in,
   input  logic            instr_valid_in,
   input  logic [XLEN-1:0] pc_in,
   output logic [4:0]      rs1_unreg_out,
   output logic [4:0]      rs2_unreg_out,
   output logic            rs1_read_unreg_out,
   output logic            rs2_read_unreg_out,
   output logic            valid_out,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      rd_out,
   output logic            rd_write_out,
   output logic            alu_non_zero_out
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic [6:0]      opc;
   logic [4:0]      rd_f;
   logic            supported;
   logic [XLEN-1:0] imm_d;
   logic signed [31:0] imm_u32;

   // decode stage registers
   logic [6:0]      opc_q;
   logic [2:0]      f3_q;
   logic            f7b5_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] op1_q;
   logic [XLEN-1:0] op2_q;
   logic            valid_q;
   logic            wr_q;

   // execute stage registers
   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_out_q;
   logic            rd_write_q;
   logic            nz_q;

   logic [XLEN-1:0] rf_q [REGS];
   logic [XLEN-1:0] op1_d, op2_d;
   logic [XLEN-1:0] alu_a, alu_b, alu;
   logic [4:0]      shamt;

   assign opc           = instr_in[6:0];
   assign rd_f          = instr_in[11:7];
   assign rs1_unreg_out = instr_in[19:15];
   assign rs2_unreg_out = instr_in[24:20];

   assign supported          = (opc == OPC_OP) || (opc == OPC_OPIMM) ||
                               (opc == OPC_LUI) || (opc == OPC_AUIPC);
   assign rs1_read_unreg_out = (opc == OPC_OP) || (opc == OPC_OPIMM);
   assign rs2_read_unreg_out = (opc == OPC_OP);

   assign imm_u32 = {instr_in[31:12], 12'b0};

   always_comb begin
      imm_d = XLEN'($signed(instr_in[31:20]));
      if (opc == OPC_LUI || opc == OPC_AUIPC)
         imm_d = XLEN'(imm_u32);
   end

   // Bypass priority: in-flight execute result, then registered result, then regfile.
   always_comb begin
      op1_d = rf_q[rs1_unreg_out];
      if (rs1_unreg_out == 5'd0)
         op1_d = '0;
      else if (valid_q && wr_q && rd_q == rs1_unreg_out)
         op1_d = alu;
      else if (rd_write_q && rd_out_q == rs1_unreg_out)
         op1_d = result_q;

      op2_d = rf_q[rs2_unreg_out];
      if (rs2_unreg_out == 5'd0)
         op2_d = '0;
      else if (valid_q && wr_q && rd_q == rs2_unreg_out)
         op2_d = alu;
      else if (rd_write_q && rd_out_q == rs2_unreg_out)
         op2_d = result_q;
   end

   always_comb begin
      alu_a = op1_q;
      alu_b = (opc_q == OPC_OP) ? op2_q : imm_q;
      shamt = alu_b[4:0];
      alu   = '0;
      case (opc_q)
         OPC_LUI:   alu = imm_q;
         OPC_AUIPC: alu = pc_q + imm_q;
         default: begin
            case (f3_q)
               3'b000: begin
                  if (opc_q == OPC_OP && f7b5_q) alu = alu_a - alu_b;
                  else                           alu = alu_a + alu_b;
               end
               3'b001: alu = alu_a << shamt;
               3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
               3'b011: alu = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
               3'b100: alu = alu_a ^ alu_b;
               3'b101: begin
                  // kept as separate statements so the signed shift stays arithmetic
                  if (f7b5_q) alu = $signed(alu_a) >>> shamt;
                  else        alu = alu_a >> shamt;
               end
               3'b110: alu = alu_a | alu_b;
               default: alu = alu_a & alu_b;
            endcase
         end
      endcase
   end

   always_ff @(posedge req or negedge reset) begin
      if (!reset) begin
         opc_q      <= '0;
         f3_q       <= '0;
         f7b5_q     <= 1'b0;
         rd_q       <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         valid_q    <= 1'b0;
         wr_q       <= 1'b0;
         result_q   <= '0;
         rd_out_q   <= '0;
         rd_write_q <= 1'b0;
         nz_q       <= 1'b0;
      end else begin
         opc_q      <= opc;
         f3_q       <= instr_in[14:12];
         f7b5_q     <= instr_in[30];
         rd_q       <= rd_f;
         imm_q      <= imm_d;
         pc_q       <= pc_in;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         valid_q    <= instr_valid_in && supported;
         wr_q       <= instr_valid_in && supported && (rd_f != 5'd0);
         result_q   <= alu;
         rd_out_q   <= rd_q;
         rd_write_q <= valid_q && wr_q;
         nz_q       <= (alu != '0);
      end
   end

   always_ff @(posedge req or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REGS; i++)
            rf_q[i] <= '0;
      end else if (rd_write_q && rd_out_q != 5'd0) begin
         rf_q[rd_out_q] <= result_q;
      end
   end

   assign valid_out        = valid_q;
   assign result_out       = result_q;
   assign rd_out           = rd_out_q;
   assign rd_write_out     = rd_write_q;
   assign alu_non_zero_out = nz_q;

endmodule

// File: tb/tb_decode_execute.sv
// Directed plus random bench for decode_execute against an architectural
// (program-order) register model; bypassing must make the pipeline invisible.
module tb_decode_execute;

   logic        req = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr_in = '0;
   logic        instr_valid_in = 1'b0;
   logic [31:0] pc_in = '0;
   logic [4:0]  rs1_unreg_out, rs2_unreg_out;
   logic        rs1_read_unreg_out, rs2_read_unreg_out;
   logic        valid_out;
   logic [31:0] result_out;
   logic [4:0]  rd_out;
   logic        rd_write_out;
   logic        alu_non_zero_out;

   decode_execute dut (
      .req(req), .reset(reset), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
      .pc_in(pc_in), .rs1_unreg_out(rs1_unreg_out), .rs2_unreg_out(rs2_unreg_out),
      .rs1_read_unreg_out(rs1_read_unreg_out), .rs2_read_unreg_out(rs2_read_unreg_out),
      .valid_out(valid_out), .result_out(result_out), .rd_out(rd_out),
      .rd_write_out(rd_write_out), .alu_non_zero_out(alu_non_zero_out)
   );

   always #5 req = ~req;

   typedef struct {
      logic        v;
      logic        w;
      logic [4:0]  rd;
      logic [31:0] res;
   } exp_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mreg [32];
   exp_t        prev;
   logic        have_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   // Architectural reference: executes in program order on mreg.
   task automatic model(input logic [31:0] ins, input logic iv, input logic [31:0] pc,
                        output exp_t e);
      logic [6:0]  opc;
      logic [31:0] a, b, r, iimm, uimm;
      int          sh;
      opc  = ins[6:0];
      iimm = {{20{ins[31]}}, ins[31:20]};
      uimm = {ins[31:12], 12'h000};
      a    = mreg[ins[19:15]];
      b    = (opc == 7'b0110011) ? mreg[ins[24:20]] : iimm;
      sh   = int'(b % 32);
      r    = '0;
      if (opc == 7'b0110111) r = uimm;
      else if (opc == 7'b0010111) r = pc + uimm;
      else begin
         case (ins[14:12])
            3'd0: r = (opc == 7'b0110011 && ins[30]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               r = a >> sh;
               if (ins[30] && a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      e.v   = iv && (opc == 7'b0110011 || opc == 7'b0010011 ||
                     opc == 7'b0110111 || opc == 7'b0010111);
      e.rd  = ins[11:7];
      e.w   = e.v && (ins[11:7] != 5'd0);
      e.res = r;
      if (e.w) mreg[ins[11:7]] = r;
   endtask

   task automatic step(input logic [31:0] ins, input logic iv, input logic [31:0] pc);
      exp_t e;
      logic [6:0] opc;
      opc = ins[6:0];
      instr_in = ins; instr_valid_in = iv; pc_in = pc;
      #1;
      chk("rs1_idx", rs1_unreg_out, ins[19:15]);
      chk("rs2_idx", rs2_unreg_out, ins[24:20]);
      chk("rs1_rd", rs1_read_unreg_out, (opc == 7'b0110011 || opc == 7'b0010011));
      chk("rs2_rd", rs2_read_unreg_out, (opc == 7'b0110011));
      model(ins, iv, pc, e);
      @(posedge req); #1;
      chk("valid", valid_out, e.v);
      if (have_prev) begin
         chk("rd_write", rd_write_out, prev.w);
         if (prev.v) begin
            chk("result", result_out, prev.res);
            chk("rd", rd_out, prev.rd);
            chk("nz", alu_non_zero_out, (prev.res != 0));
         end
      end
      prev = e;
      have_prev = 1'b1;
   endtask

   task automatic do_reset();
      #1 reset = 1'b0;
      instr_valid_in = 1'b0;
      instr_in = '0;
      repeat (2) @(posedge req);
      #1;
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_result", result_out, 32'h0);
      chk("rst_rd", rd_out, 5'h0);
      chk("rst_wr", rd_write_out, 1'b0);
      chk("rst_nz", alu_non_zero_out, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      have_prev = 1'b0;
   endtask

   task automatic rand_instr();
      logic [31:0] ins;
      logic        iv;
      int          k;
      logic [4:0]  rd, rs1, rs2;
      k   = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      iv  = 1'b1;
      case (k)
         0, 1, 2, 3: ins = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rs2, rs1,
                                 3'($urandom_range(0, 7)), rd);
         4, 5, 6:    ins = enc_i(12'($urandom), rs1, 3'($urandom_range(0, 7)), rd);
         7:          ins = {20'($urandom), rd, 7'b0110111};
         8:          ins = {20'($urandom), rd, 7'b0010111};
         default: begin
            ins = $urandom_range(0, 1) ? {25'($urandom), 7'b0000011}
                                       : enc_i(12'($urandom), rs1, 3'd0, rd);
            iv  = $urandom_range(0, 1) ? 1'b1 : 1'b0;
         end
      endcase
      step(ins, iv, $urandom);
   endtask

   initial begin
      reset = 1'b1;
      #2;
      do_reset();
      // every register reads zero after reset
      for (int i = 1; i < 32; i++) step(enc_r(7'h00, 5'(i), 5'(i), 3'd0, 5'd0), 1'b1, 32'h0);

      step(32'h00108093, 1'b1, 32'h0);
      step(32'h00118193, 1'b1, 32'h4);
      step(32'h00120213, 1'b1, 32'h8);
      step(32'h00108133, 1'b1, 32'hC);

      step(enc_i(12'hFFF, 5'd0, 3'd0, 5'd5), 1'b1, 32'h10);
      step(enc_r(7'h20, 5'd5, 5'd0, 3'd0, 5'd6), 1'b1, 32'h14);
      step(enc_i(12'h404, 5'd5, 3'd5, 5'd7), 1'b1, 32'h18);
      step(enc_i(12'h01C, 5'd5, 3'd5, 5'd7), 1'b1, 32'h1C);

      step(enc_i(12'h001, 5'd0, 3'd0, 5'd8), 1'b1, 32'h20);
      step(enc_r(7'h00, 5'd8, 5'd5, 3'd2, 5'd11), 1'b1, 32'h24);
      step(enc_r(7'h00, 5'd8, 5'd5, 3'd3, 5'd12), 1'b1, 32'h28);

      step(enc_i(12'h005, 5'd0, 3'd0, 5'd0), 1'b1, 32'h2C);
      step(enc_r(7'h00, 5'd0, 5'd0, 3'd6, 5'd13), 1'b1, 32'h30);
      step({25'h0123456, 7'b0000011}, 1'b1, 32'h34);
      step(enc_i(12'h07F, 5'd0, 3'd0, 5'd14), 1'b0, 32'h38);

      step({20'h12345, 5'd9, 7'b0110111}, 1'b1, 32'h3C);
      step({20'h00001, 5'd10, 7'b0010111}, 1'b1, 32'h100);

      for (int n = 0; n < 300; n++) rand_instr();
      do_reset();
      for (int n = 0; n < 300; n++) rand_instr();
      step(32'h0, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
